// File: rtl/nic_interface.sv
`default_nettype none
// ============================================================================
// Module   : nic_interface
// Purpose  : Processor-side NIC between a processing element and the PE port
//            of the ring router. One single-entry output channel buffer
//            (processor -> router) and one single-entry input channel buffer
//            (router -> processor), each with a full flag, reached through a
//            2-bit register address space. Injection is gated by the ring's
//            even/odd polarity so each packet enters on the virtual channel
//            encoded in its header bit VC_BIT.
//
// Ports    : clk          - clock, all state updates on posedge
//            reset        - synchronous, active-low reset
//            addr         - processor register address
//                           (00 in buf, 01 in status, 10 out buf, 11 out status)
//            d_in         - processor write data
//            d_out        - processor read data (registered, 1-cycle latency)
//            nicEn        - processor access enable
//            nicWrEn      - 1 = write, 0 = read
//            net_polarity - router polarity (0 even, 1 odd)
//            net_so       - send strobe to router PE input
//            net_ro       - router PE input ready
//            net_do       - packet to router
//            net_si       - send strobe from router PE output
//            net_ri       - ready to router PE output
//            net_di       - packet from router
//
// Revision : 1.0 - initial release
// ============================================================================
module nic_interface #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_polarity,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);

    localparam logic [1:0] c_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] c_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] c_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] c_ADDR_OUT_STAT = 2'b11;

    logic [DATA_W-1:0] r_out_buf;
    logic              r_out_full;
    logic [DATA_W-1:0] r_in_buf;
    logic              r_in_full;
    logic [DATA_W-1:0] r_d_out;

    logic              w_inject;
    logic              w_accept;
    logic              w_proc_wr;
    logic              w_proc_rd;
    logic [DATA_W-1:0] w_rd_data;

    // A packet only leaves on the ring phase that matches its VC bit, so the
    // router sees it on the intended virtual channel.
    assign w_inject  = reset & r_out_full & net_ro &
                       (net_polarity == r_out_buf[VC_BIT]);
    assign net_ri    = reset & ~r_in_full;
    assign w_accept  = net_si & net_ri;
    assign w_proc_wr = nicEn & nicWrEn;
    assign w_proc_rd = nicEn & ~nicWrEn;

    assign net_so = w_inject;
    assign net_do = r_out_buf;
    assign d_out  = r_d_out;

    always_comb begin
        w_rd_data = '0;
        case (addr)
            c_ADDR_IN_BUF:   w_rd_data = r_in_buf;
            c_ADDR_IN_STAT:  w_rd_data = {{(DATA_W-1){1'b0}}, r_in_full};
            c_ADDR_OUT_BUF:  w_rd_data = '0;
            c_ADDR_OUT_STAT: w_rd_data = {{(DATA_W-1){1'b0}}, r_out_full};
            default:         w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_d_out    <= '0;
        end else begin
            // Output side: a write landing on the injection edge still sees
            // the buffer full and is dropped; software polls status to retry.
            if (w_inject) begin
                r_out_full <= 1'b0;
            end else if (w_proc_wr && (addr == c_ADDR_OUT_BUF) && !r_out_full) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end

            // Input side: arrival and consume are mutually exclusive because
            // net_ri is low whenever the buffer is full.
            if (w_accept) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_proc_rd && (addr == c_ADDR_IN_BUF) && r_in_full) begin
                r_in_full <= 1'b0;
            end

            r_d_out <= w_proc_rd ? w_rd_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nic_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic_interface
// Purpose  : Self-checking bench for nic_interface. Directed scenarios plus a
//            randomized run, all compared against a channel-level reference
//            model (queues of pending packets) held in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic_interface;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel holds at most one pending packet.
    logic [63:0] m_out_q[$];
    logic [63:0] m_in_q[$];
    logic [63:0] m_out_last;   // what net_do shows (last accepted write)
    logic [63:0] m_in_last;    // what a read of 00 returns (last arrival)
    logic [63:0] m_dout;
    bit          m_dout_known;

    nic_interface #(.DATA_W(64), .VC_BIT(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_so();
        return reset && (m_out_q.size() != 0) && net_ro &&
               (net_polarity == m_out_q[0][31]);
    endfunction

    function automatic bit exp_ri();
        return reset && (m_in_q.size() == 0);
    endfunction

    // Advance one clock edge, applying the channel rules to the model using
    // the inputs present at that edge.
    task automatic tick();
        bit          so;
        bit          ri;
        logic [63:0] rd;
        so = exp_so();
        ri = exp_ri();
        rd = 64'd0;
        if (nicEn && !nicWrEn) begin
            case (addr)
                2'd0: rd = m_in_last;
                2'd1: rd = {63'd0, m_in_q.size() != 0};
                2'd2: rd = 64'd0;
                default: rd = {63'd0, m_out_q.size() != 0};
            endcase
        end
        @(posedge clk);
        if (!reset) begin
            m_out_q.delete();
            m_in_q.delete();
            m_out_last   = 64'd0;
            m_in_last    = 64'd0;
            m_dout       = 64'd0;
            m_dout_known = 1'b1;
        end else begin
            m_dout       = rd;
            m_dout_known = !(nicEn && nicWrEn);
            if (so)
                void'(m_out_q.pop_front());
            else if (nicEn && nicWrEn && addr == 2'd2 && m_out_q.size() == 0) begin
                m_out_q.push_back(d_in);
                m_out_last = d_in;
            end
            if (net_si && ri) begin
                m_in_q.push_back(net_di);
                m_in_last = net_di;
            end else if (nicEn && !nicWrEn && addr == 2'd0 && m_in_q.size() != 0)
                void'(m_in_q.pop_front());
        end
        #1;
    endtask

    task automatic proc_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic proc_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; net_si = 1'b1; net_di = {$urandom, $urandom};
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = {$urandom, $urandom};
        net_ro = 1'b1; net_polarity = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (d_out !== 64'd0 || net_so !== 1'b0 || net_ri !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: d_out=%h so=%b ri=%b required 0/0/0", d_out, net_so, net_ri);
            end
        end
        checks++;
        if (net_do !== 64'd0) begin
            errors++;
            $display("FAIL reset_net_do: got %h required 0", net_do);
        end
        reset = 1'b1; net_si = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0;
        proc_read(2'd1);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_in_status: got %h required 0", d_out);
        end
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_out_status: got %h required 0", d_out);
        end
    endtask

    task automatic test_inject_polarity();
        logic [63:0] pkt;
        bit          done;
        bit          start;
        pkt = 64'h0000_00AA_8004_0000;
        net_ro = 1'b1;
        proc_write(2'd2, pkt);
        done  = 1'b0;
        start = 1'($urandom);
        for (int i = 0; i < 6 && !done; i++) begin
            net_polarity = start ^ 1'(i);
            #1;
            checks++;
            if (net_so !== exp_so() || (net_so === 1'b1 && net_polarity !== 1'b1)) begin
                errors++;
                $display("FAIL inject_so: got %b required %b (polarity %b)", net_so, exp_so(), net_polarity);
            end
            checks++;
            if (net_do !== pkt) begin
                errors++;
                $display("FAIL inject_net_do: got %h required %h", net_do, pkt);
            end
            done = exp_so();
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL inject_timeout: got no injection required one within 2 cycles");
        end
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL inject_status: got %h required 0", d_out);
        end
    endtask

    task automatic test_backpressure();
        net_ro = 1'b0;
        proc_write(2'd2, 64'h11);
        proc_write(2'd2, 64'h22);
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd1) begin
            errors++;
            $display("FAIL bp_status: got %h required 1", d_out);
        end
        net_ro = 1'b1; net_polarity = 1'b0;
        #1;
        checks++;
        if (net_so !== 1'b1 || net_do !== 64'h11) begin
            errors++;
            $display("FAIL bp_release: so=%b do=%h required 1/%h", net_so, net_do, 64'h11);
        end
        tick();
        net_ro = 1'b0;
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL bp_drained: got %h required 0", d_out);
        end
    endtask

    task automatic test_eject();
        logic [63:0] pkt;
        pkt = 64'hDEAD_BEEF_4000_0000;
        checks++;
        if (net_ri !== 1'b1) begin
            errors++;
            $display("FAIL eject_ri_idle: got %b required 1", net_ri);
        end
        net_si = 1'b1; net_di = pkt;
        tick();
        net_si = 1'b0;
        checks++;
        if (net_ri !== 1'b0) begin
            errors++;
            $display("FAIL eject_ri_full: got %b required 0", net_ri);
        end
        proc_read(2'd1);
        checks++;
        if (d_out !== 64'd1) begin
            errors++;
            $display("FAIL eject_status: got %h required 1", d_out);
        end
        proc_read(2'd0);
        checks++;
        if (d_out !== pkt || net_ri !== 1'b1) begin
            errors++;
            $display("FAIL eject_consume: d_out=%h ri=%b required %h/1", d_out, net_ri, pkt);
        end
    endtask

    task automatic test_input_full();
        logic [63:0] pkt;
        pkt = {$urandom, $urandom};
        net_si = 1'b1; net_di = pkt;
        tick();
        net_di = 64'h5;
        tick();
        net_si = 1'b0;
        proc_read(2'd0);
        checks++;
        if (d_out !== pkt) begin
            errors++;
            $display("FAIL full_keep: got %h required %h", d_out, pkt);
        end
        proc_read(2'd1);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL full_status: got %h required 0", d_out);
        end
    endtask

    task automatic test_same_edge();
        logic [63:0] pkt;
        pkt = {$urandom, $urandom};
        net_ro = 1'b0;
        proc_write(2'd2, pkt);
        net_ro = 1'b1; net_polarity = pkt[31];
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h33;
        #1;
        checks++;
        if (net_so !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_so: got %b required 1", net_so);
        end
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
        checks++;
        if (net_do !== pkt || net_so !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_drop: do=%h so=%b required %h/0", net_do, net_so, pkt);
        end
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd0) begin
            errors++;
            $display("FAIL same_edge_status: got %h required 0", d_out);
        end
        proc_write(2'd2, 64'h33);
        proc_read(2'd3);
        checks++;
        if (d_out !== 64'd1 || net_do !== 64'h33) begin
            errors++;
            $display("FAIL same_edge_rewrite: status=%h do=%h required 1/%h", d_out, net_do, 64'h33);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 59) != 0);
            nicEn        = 1'($urandom);
            nicWrEn      = 1'($urandom);
            addr         = 2'($urandom);
            d_in         = {$urandom, $urandom};
            net_polarity = 1'($urandom);
            net_ro       = ($urandom_range(0, 3) != 0);
            net_si       = 1'($urandom);
            net_di       = {$urandom, $urandom};
            #1;
            checks++;
            if (net_so !== exp_so() || net_ri !== exp_ri()) begin
                errors++;
                $display("FAIL rand_hs[%0d]: so=%b ri=%b required %b/%b", i, net_so, net_ri, exp_so(), exp_ri());
            end
            checks++;
            if (net_do !== m_out_last) begin
                errors++;
                $display("FAIL rand_net_do[%0d]: got %h required %h", i, net_do, m_out_last);
            end
            tick();
            if (m_dout_known) begin
                checks++;
                if (d_out !== m_dout) begin
                    errors++;
                    $display("FAIL rand_d_out[%0d]: got %h required %h", i, d_out, m_dout);
                end
            end
        end
        reset = 1'b1; nicEn = 1'b0; net_si = 1'b0; net_ro = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = 2'd0; d_in = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_polarity = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = 64'd0;
        m_out_last = 64'd0; m_in_last = 64'd0; m_dout = 64'd0; m_dout_known = 1'b0;
        test_reset();
        test_inject_polarity();
        test_backpressure();
        test_eject();
        test_input_full();
        test_same_edge();
        // Return to a known state before the randomized run.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nic_interface.md
# nic_interface

Processor-side network interface controller (NIC) between a processing element and the PE port of the ring router. It holds one 64-bit output channel buffer (processor → router) and one 64-bit input channel buffer (router → processor), each with a full flag. The processor reaches these through a 2-bit register address space. Injection into the router is gated by the ring's even/odd polarity so that each packet enters on the virtual channel encoded in its header.

## Interface
- DATA_W, 64, packet and processor data width
- VC_BIT, 31, header bit selecting the virtual channel (0 = even, 1 = odd)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; 0 on a posedge resets all state
- addr  in  2  processor register address
- d_in  in  64  processor write data
- d_out  out  64  processor read data, registered
- nicEn  in  1  processor access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_polarity  in  1  router polarity; 0 = even cycle, 1 = odd cycle
- net_so  out  1  send strobe to router PE input (pesi)
- net_ro  in  1  router PE input ready (peri)
- net_do  out  64  packet to router (pedi)
- net_si  in  1  send strobe from router PE output (peso)
- net_ri  out  1  ready to router PE output (pero)
- net_di  in  64  packet from router (pedo)

## Operation
- Header fields, fixed at the NIC boundary: [31] vc, [30] direction (0 = cw, 1 = ccw), [25:18] hop count, [63:32] payload. The NIC does not modify packets.
- Address map:
  - 00 = input buffer. Read only; a read consumes it.
  - 01 = input status. Read returns {63'b0, in_full}.
  - 10 = output buffer. Write only; reads return 0.
  - 11 = output status. Read returns {63'b0, out_full}.
- Processor write: occurs when nicEn=1, nicWrEn=1, addr=10.
  - If out_full=0 at the edge: out_buf ← d_in, out_full ← 1.
  - If out_full=1: the write is dropped silently.
  - Writes to any other address are ignored.
- Processor read: occurs when nicEn=1, nicWrEn=0.
  - d_out ← addressed value at the edge.
  - A read of addr 00 with in_full=1 also clears in_full at the same edge.
  - A read of addr 00 with in_full=0 returns the stale in_buf and has no side effect.
  - With nicEn=0, d_out ← 0.
- Injection (combinational): net_so = reset & out_full & net_ro & (net_polarity == out_buf[VC_BIT]). net_do = out_buf at all times.
  - On an edge where net_so=1, out_full ← 0.
- Ejection: net_ri = reset & ~in_full (combinational).
  - On an edge where net_si & net_ri: in_buf ← net_di, in_full ← 1.
  - net_si while net_ri=0 is a router protocol error; the packet is ignored and in_buf is unchanged.
- Simultaneous events:
  - Processor write to 10 and injection on the same edge: the write sees out_full=1 and is dropped. The processor must poll addr 11.
  - Processor read of 00 and arrival on the same edge: cannot occur, because net_ri=0 while in_full=1.
  - Write and read paths are independent. An output-side write and an input-side arrival on the same edge both take effect.

## Timing
- Reset (reset=0 at posedge): out_full=0, in_full=0, out_buf=0, in_buf=0, d_out=0. While reset=0: net_so=0, net_ri=0. net_do=0 after the reset edge.
- Reset mid-operation discards both buffers. No partial packet is possible, since a transfer is a single-cycle handshake.
- Read latency is 1 cycle: d_out is valid the cycle after the nicEn read edge.
- Write to injection:
  - Write edge T sets out_full.
  - The earliest net_so=1 is during cycle T+1, provided polarity matches.
  - With net_ro=1 held, injection waits at most 1 extra cycle for polarity to match.
- Arrival to processor visibility:
  - Arrival edge T sets in_full.
  - A status read issued at T+1 returns 1 in d_out at T+2.
- Throughput: at most 1 packet per 2 cycles per direction, because each buffer is single-entry and needs a fill edge and a drain edge.

## Test plan
- Reset: hold reset=0 for 2 cycles with net_si=1 and nicEn=1 (write). Required: d_out=0, net_so=0, net_ri=0, both status reads return 0 afterwards.
- Injection with polarity:
  - Write 0x0000_00AA_8004_0000 (vc=1, hop=0x01) to addr 10 with net_ro=1.
  - Required: net_so asserts only in a cycle with net_polarity=1, net_do equals the written value, and addr 11 reads 0 after that edge.
- Output back-pressure:
  - Hold net_ro=0, write 0x11 (vc=0), then write 0x22.
  - Required: status 11 reads 1, the second write is dropped, and after net_ro=1 at an even cycle net_do=0x11.
- Ejection and consume:
  - Drive net_si=1, net_di=0xDEAD_BEEF_4000_0000.
  - Required: net_ri drops the next cycle. Read addr 01 returns 1; read addr 00 returns 0xDEAD_BEEF_4000_0000 one cycle later; net_ri returns to 1 after the read edge.
- Input full: with in_full=1, drive net_si=1 with 0x5. Required: in_buf is unchanged, and the addr 00 read returns the original packet.
- Same-edge write/inject:
  - With out_full=1 and an injection edge, also write 0x33 to addr 10.
  - Required: 0x33 is dropped and out_full=0 after the edge. A rewrite of 0x33 then succeeds.
